div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_pkg.sv | 14 +
 rtl/div_sched_if.sv | 25 ++
 rtl/div_core.sv | 40 ++++
 rtl/div_sched.sv | 115 +++++++++++
 tb/tb_div_sched.sv | 112 +++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the ratio-programmable clock divider scheduler.
package div_pkg;

   localparam int unsigned RATIO_W       = 8;
   localparam int unsigned MIN_RATIO     = 2;
   localparam int unsigned DEFAULT_RATIO = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/div_sched_if.sv
// Ratio-change request handshake between a configuring agent and the divider scheduler.
interface div_sched_if #(
   parameter int unsigned WIDTH = div_pkg::RATIO_W
);

   logic             cfg_valid;
   logic [WIDTH-1:0] cfg_ratio;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_ratio,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ratio,
      output cfg_ready,
      output cfg_err
   );

endinterface

// File: rtl/div_core.sv
// Period counter with registered divided waveform and end-of-period tick.
// Outputs are registered from next-cycle values so they always describe the live count.
module div_core
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = RATIO_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_d,
   input  logic             clr,
   input  logic [WIDTH-1:0] ratio_d,
   output logic [WIDTH-1:0] cnt,
   output logic             div_out,
   output logic             tick
);

   logic [WIDTH-1:0] cnt_d;

   // Count only while running; a clear or halt restarts the period at zero.
   always_comb begin
      cnt_d = '0;
      if (run_d && !clr) begin
         cnt_d = cnt + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         div_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_d;
         div_out <= run_d && (cnt_d < (ratio_d >> 1));
         tick    <= run_d && (cnt_d == ratio_d - WIDTH'(1));
      end
   end

endmodule

// File: rtl/div_sched.sv
// Divider scheduler: run/halt FSM and ratio-change handshake around div_core.
// A new ratio takes effect only on a period boundary, so no partial periods are emitted.
module div_sched #(
   parameter int unsigned WIDTH         = div_pkg::RATIO_W,
   parameter int unsigned DEFAULT_RATIO = div_pkg::DEFAULT_RATIO
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   div_sched_if.slave  cfg,
   output logic        div_out,
   output logic        tick,
   output logic        busy
);

   import div_pkg::state_t;
   import div_pkg::IDLE;
   import div_pkg::RUN;
   import div_pkg::PEND;
   import div_pkg::MIN_RATIO;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, p_q, p_d, cnt;
   logic             ready_q, err_q, err_d, busy_q;
   logic             wrap, accept, ratio_ok, take, clr, run_d;

   assign wrap     = (state_q != IDLE) && (cnt == a_q - WIDTH'(1));
   assign accept   = cfg.cfg_valid && ready_q;
   assign ratio_ok = (cfg.cfg_ratio >= WIDTH'(MIN_RATIO));
   assign take     = accept && ratio_ok;
   assign run_d    = (state_d != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (take && !wrap) state_d = PEND;
            PEND:    if (wrap) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Ratio bookkeeping: a pending ratio is promoted at wrap or when the divider halts.
   always_comb begin
      a_d   = a_q;
      p_d   = p_q;
      clr   = 1'b0;
      err_d = accept && !ratio_ok;
      if (!en) begin
         clr = 1'b1;
         if (state_q == PEND) a_d = p_q;
         else if (take)       a_d = cfg.cfg_ratio;
      end else begin
         case (state_q)
            IDLE: begin
               clr = 1'b1;
               if (take) a_d = cfg.cfg_ratio;
            end
            RUN: begin
               clr = wrap;
               if (take) begin
                  if (wrap) a_d = cfg.cfg_ratio;
                  else      p_d = cfg.cfg_ratio;
               end
            end
            PEND: begin
               clr = wrap;
               if (wrap) a_d = p_q;
            end
            default: clr = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= WIDTH'(DEFAULT_RATIO);
         p_q     <= '0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         p_q     <= p_d;
         ready_q <= (state_d != PEND);
         err_q   <= err_d;
         busy_q  <= (state_d == PEND);
      end
   end

   div_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .rst     (rst),
      .run_d   (run_d),
      .clr     (clr),
      .ratio_d (a_d),
      .cnt     (cnt),
      .div_out (div_out),
      .tick    (tick)
   );

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: directed per-cycle vectors with hand-derived outputs.
module tb_div_sched;

   typedef struct {
      int         idx;
      logic [4:0] val;
   } exp_t;

   logic clk, rst, en;
   logic div_out, tick, busy;
   exp_t exp_q[$];
   int   vec_id   = 0;
   int   compared = 0;
   int   mismatched = 0;

   div_sched_if #(.WIDTH(8)) cfg_if ();

   div_sched #(.WIDTH(8), .DEFAULT_RATIO(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cfg     (cfg_if.slave),
      .div_out (div_out),
      .tick    (tick),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply inputs for the next edge; exp = {div_out,tick,busy,cfg_ready,cfg_err} after it.
   task automatic step(input logic r, input logic e, input logic v,
                       input logic [7:0] n, input logic [4:0] exp);
      exp_t x;
      rst = r; en = e; cfg_if.cfg_valid = v; cfg_if.cfg_ratio = n;
      @(posedge clk);
      #1;
      x.idx = vec_id;
      x.val = exp;
      exp_q.push_back(x);
      vec_id++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         automatic exp_t x = exp_q.pop_front();
         automatic logic [4:0] act = {div_out, tick, busy, cfg_if.cfg_ready, cfg_if.cfg_err};
         compared++;
         if (act !== x.val) begin
            mismatched++;
            $display("FAIL vec%0d: got div/tick/busy/ready/err=%b required %b", x.idx, act, x.val);
         end
      end
   end

   initial begin
      // Reset for 20 ns
      step(1,0,0,0,5'b00010); step(1,0,0,0,5'b00010);
      // Default ratio 5: 2 high, 3 low, tick on last cycle
      for (int k = 0; k < 2; k++) begin
         step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010); step(0,1,0,0,5'b00010);
         step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      end
      // Request 8 at cnt=1 -> PEND until wrap, then 8-cycle period with 4 high
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010);
      step(0,1,1,8,5'b00100); step(0,1,0,0,5'b00100); step(0,1,0,0,5'b01100);
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010);
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b00010); step(0,1,0,0,5'b00010);
      step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      // Request 5 on wrap of the 8-period: takes effect immediately, no busy
      step(0,1,1,5,5'b10010); step(0,1,0,0,5'b10010); step(0,1,0,0,5'b00010);
      step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      // Request 3 exactly at cnt=4: next periods are 3 cycles, busy stays low
      step(0,1,1,3,5'b10010); step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      // Back to 5, then illegal ratio 1 -> single err pulse, period unchanged
      step(0,1,1,5,5'b10010); step(0,1,1,1,5'b10011); step(0,1,0,0,5'b00010);
      step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010); step(0,1,0,0,5'b10010);
      // PEND with P=6, drop en, re-raise -> 6-cycle periods
      step(0,1,1,6,5'b10100); step(0,0,0,0,5'b00010); step(0,0,0,0,5'b00010);
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010);
      step(0,1,0,0,5'b00010); step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      step(0,1,0,0,5'b10010);
      // PEND with P=9, reset at cnt=3 -> P discarded, ratio back to 5
      step(0,1,1,9,5'b10100); step(0,1,0,0,5'b10100); step(0,1,0,0,5'b00100);
      step(1,1,1,7,5'b00010);
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010); step(0,1,0,0,5'b00010);
      step(0,1,0,0,5'b00010); step(0,1,0,0,5'b01010);
      // Halt, load ratio 4 while idle, reject ratio 0, then run 4-cycle periods
      step(0,0,0,0,5'b00010); step(0,0,1,4,5'b00010); step(0,0,1,0,5'b00011);
      step(0,1,0,0,5'b10010); step(0,1,0,0,5'b10010); step(0,1,0,0,5'b00010);
      step(0,1,0,0,5'b01010); step(0,1,0,0,5'b10010);
      cfg_if.cfg_valid = 1'b0;
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d entries left required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion required finish before 100000 ns");
      $fatal(1);
   end

endmodule
